// File: rtl/pin_cmd_responder_pkg.sv
// pin_cmd_responder_pkg
//   Shared definitions for the pin command responder: data/address widths,
//   register-file geometry, opcode and FSM state encodings, and a small helper
//   used by the INC operation.
package pin_cmd_responder_pkg;

  localparam int DATA_W      = 8;
  localparam int REG_COUNT   = 16;
  localparam int STATUS_ADDR = 15;
  localparam int ADDR_W      = $clog2(REG_COUNT);

  // STATUS_ADDR at address width, for direct comparison against captured addresses
  localparam logic [ADDR_W-1:0] STATUS_SEL = STATUS_ADDR[ADDR_W-1:0];

  // Host command opcodes as carried on ui_in[6:5]
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_INC   = 2'b11
  } opcode_e;

  // Transaction FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

  // True when incrementing v rolls over from all-ones to zero
  function automatic logic inc_wraps(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}});
  endfunction

endpackage

// File: rtl/pin_cmd_responder_sync2.sv
// sync2
//   Two-flop synchronizer for a single asynchronous control bit.
//   Both flops clear to 0 on asynchronous active-low reset.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output (two clk edges of latency)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pin_cmd_responder.sv
// pin_cmd_responder
//   Four-phase handshaked command responder. The host raises ui_in[7] with an
//   opcode/address on ui_in and write data on uio_in; the block executes the
//   command against a 16-entry register file (entry 15 is a read-only view of
//   the completed-transaction counter), raises ack, and waits for the strobe
//   to drop before returning to idle.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   ena     - block enable; low forces the FSM back to idle
//   ui_in   - [7] strobe, [6:5] opcode, [4] unused, [3:0] address
//   uio_in  - write data
//   uo_out  - [7] ack, [6] err, [5:0] transaction counter low bits
//   uio_out - read data (driven only while uio_oe is all ones)
//   uio_oe  - bidirectional output enable, all ones only in ACK of a READ
module pin_cmd_responder
  import pin_cmd_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Number of cycles after reset before the synchronizer output reflects the
  // pin rather than its own reset value.
  localparam logic [1:0] SETTLE_DONE = 2'd2;

  logic strobe;
  logic unused_cmd_bit;

  assign unused_cmd_bit = ui_in[4];

  sync2 u_strobe_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_in[7]),
    .q     (strobe)
  );

  state_e              state_q, state_d;
  opcode_e             op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   regs_q [STATUS_ADDR];
  logic [DATA_W-1:0]   regs_d [STATUS_ADDR];
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic                err_q, err_d;
  logic                armed_q, armed_d;
  logic [1:0]          settle_q, settle_d;

  logic                is_status;
  logic [DATA_W-1:0]   rd_val;
  logic                ack;
  logic                drive_rd;

  assign is_status = (addr_q == STATUS_SEL);
  // Status reads see the counter as it stands before this transaction's
  // increment, because the increment lands on the same edge as the read.
  assign rd_val    = is_status ? cnt_q : regs_q[addr_q];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    rbuf_d   = rbuf_q;
    err_d    = err_q;
    armed_d  = armed_q;
    settle_d = settle_q;

    if (settle_q != SETTLE_DONE) begin
      settle_d = settle_q + 2'd1;
    end

    // A command is only accepted after the strobe has been observed low, so a
    // strobe left high across an abort, a completed handshake or a reset never
    // starts a second transaction on its own.
    if ((settle_q == SETTLE_DONE) && !strobe) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ena && strobe && armed_q) begin
          op_d    = opcode_e'(ui_in[6:5]);
          addr_d  = ui_in[3:0];
          wdata_d = uio_in;
          armed_d = 1'b0;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Effects are committed only when the transaction proceeds to ACK;
        // an ena drop here abandons it with no side effects.
        if (ena) begin
          case (op_q)
            OP_WRITE: begin
              if (is_status) begin
                err_d = 1'b1;
              end else begin
                regs_d[addr_q] = wdata_q;
                err_d          = 1'b0;
              end
            end
            OP_READ: begin
              rbuf_d = rd_val;
              err_d  = 1'b0;
            end
            OP_INC: begin
              if (is_status) begin
                err_d = 1'b1;
              end else begin
                regs_d[addr_q] = rd_val + 1'b1;
                err_d          = inc_wraps(rd_val);
              end
            end
            default: begin
              err_d = 1'b0;
            end
          endcase
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_ACK;
        end
      end

      ST_ACK: begin
        if (!strobe) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!ena) begin
      state_d = ST_IDLE;
    end

    // err is only meaningful while a transaction is in flight
    if (state_d == ST_IDLE) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      addr_q   <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < STATUS_ADDR; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q    <= '0;
      rbuf_q   <= '0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      rbuf_q   <= rbuf_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
      settle_q <= settle_d;
    end
  end

  assign ack      = (state_q == ST_ACK);
  assign drive_rd = ack && (op_q == OP_READ);

  assign uo_out   = {ack, err_q, cnt_q[5:0]};
  assign uio_oe   = drive_rd ? 8'hFF : 8'h00;
  assign uio_out  = drive_rd ? rbuf_q : 8'h00;

endmodule

// File: tb/tb_pin_cmd_responder.sv
module tb_pin_cmd_responder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec;
  int n_err;

  // Reference model state: what a host would see, at transaction granularity
  logic [7:0] mem [16];
  logic [7:0] m_cnt;

  pin_cmd_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    m_cnt = 8'h00;
  endtask

  // Applies one command to the model; returns the expected read data and err.
  task automatic model_txn(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                           output logic [7:0] rd, output logic err);
    rd  = 8'h00;
    err = 1'b0;
    case (op)
      2'd1: if (addr == 4'd15) err = 1'b1; else mem[addr] = data;
      2'd2: rd = (addr == 4'd15) ? m_cnt : mem[addr];
      2'd3: begin
        if (addr == 4'd15) err = 1'b1;
        else begin
          err       = (mem[addr] == 8'hFF);
          mem[addr] = mem[addr] + 8'd1;
        end
      end
      default: ;
    endcase
    m_cnt = m_cnt + 8'd1;
  endtask

  // Full four-phase transaction with latency and output checks.
  task automatic do_txn(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                        input int hold);
    logic [7:0] exp_rd;
    logic       exp_err;
    int         lat;
    model_txn(op, addr, data, exp_rd, exp_err);
    @(negedge clk);
    ui_in  = {1'b1, op, 1'b0, addr};
    uio_in = data;
    lat = 0;
    while (uo_out[7] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("ack_latency", lat, 4);
    check_eq("err", uo_out[6], exp_err);
    check_eq("count", uo_out[5:0], m_cnt[5:0]);
    check_eq("uio_oe", uio_oe, (op == 2'd2) ? 8'hFF : 8'h00);
    check_eq("rdata", uio_out, (op == 2'd2) ? exp_rd : 8'h00);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("ack_hold", {uo_out[7], uo_out[6]}, {1'b1, exp_err});
    end
    ui_in[7] = 1'b0;
    lat = 0;
    while (uo_out[7] !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("release_latency", lat, 3);
    check_eq("idle_out", {uo_out[7:6], uio_oe, uio_out}, 18'h0);
    check_eq("idle_count", uo_out[5:0], m_cnt[5:0]);
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat;
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] data;

    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();

    repeat (3) @(negedge clk);
    check_eq("reset_outs", {uo_out, uio_out, uio_oe}, 24'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post_reset_outs", {uo_out, uio_out, uio_oe}, 24'h0);

    // Write/read round trip
    do_txn(2'd1, 4'd3, 8'hA5, 0);
    do_txn(2'd2, 4'd3, 8'h00, 1);

    // INC wrap then read back
    do_txn(2'd1, 4'd7, 8'hFF, 0);
    do_txn(2'd3, 4'd7, 8'h00, 0);
    do_txn(2'd2, 4'd7, 8'h00, 0);

    // Long strobe hold after ack: no second transaction
    do_txn(2'd0, 4'd1, 8'h00, 20);
    repeat (3) @(negedge clk);
    check_eq("hold_no_retrigger", uo_out, {2'b00, m_cnt[5:0]});

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      op   = 2'($urandom_range(0, 3));
      addr = 4'($urandom_range(0, 15));
      data = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        addr = 4'd5;
        op   = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'd1;
      end
      do_txn(op, addr, data, $urandom_range(0, 3));
    end

    // ena dropped during ACK of a READ
    model_txn(2'd2, 4'd3, 8'h00, rd, er);
    @(negedge clk);
    ui_in = {1'b1, 2'd2, 1'b0, 4'd3};
    lat = 0;
    while (uo_out[7] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("ena_ack_latency", lat, 4);
    check_eq("ena_ack_rdata", uio_out, rd);
    ena = 1'b0;
    @(negedge clk);
    check_eq("ena_drop_ack", uo_out[7], 1'b0);
    check_eq("ena_drop_oe", uio_oe, 8'h00);
    ena = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("ena_no_retrigger", uo_out, {2'b00, m_cnt[5:0]});
    ui_in[7] = 1'b0;
    repeat (4) @(negedge clk);

    // Full register readback sweep against the model
    for (int a = 0; a < 16; a++) do_txn(2'd2, 4'(a), 8'h00, 0);

    // Reset asserted while a WRITE is in EXEC
    @(negedge clk);
    ui_in  = {1'b1, 2'd1, 1'b0, 4'd2};
    uio_in = 8'h3C;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midexec_reset_outs", {uo_out, uio_out, uio_oe}, 24'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("reset_strobe_high_no_txn", {uo_out, uio_oe}, 16'h0);
    ui_in[7] = 1'b0;
    repeat (4) @(negedge clk);

    // Status register behaviour from a fresh counter
    do_txn(2'd1, 4'd15, 8'h55, 0);
    do_txn(2'd2, 4'd15, 8'h00, 0);
    do_txn(2'd3, 4'd15, 8'h00, 0);
    do_txn(2'd2, 4'd2, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
